psic_cmd_proc: RTL and testbench
================================

Name: psic_cmd_proc

Overview:
Command processor inside PSIC, directly downstream of the serial slave receiver and upstream of its response transmitter. Accepts a 24-bit command `{opcode[7:0], data[15:0]}` and dispatches it.
- Write commands go to NV_MEM.
- Pressure reads sequence the A2D (pressure channel, then PTAT channel), apply the Tco/Offset/Gain correction with saturation, and hand a 16-bit result to the transmitter.
- A single shared 16x16 signed multiplier serves both multiplies.

Parameters:
- P_CHNL, 3'd0, A2D channel for raw pressure
- T_CHNL, 3'd1, A2D channel for PTAT
- ACK_VAL, 16'hA5A5, response to a completed NV write
- ERR_VAL, 16'hEEEE, response to an unknown opcode
- TIMEOUT, 4096, watchdog limit in clocks (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_rdy  in  1  serial slave holds a complete command
- cmd  in  24  received command; valid while cmd_rdy
- clr_cmd_rdy  out  1  one-cycle pulse when the command is accepted
- resp  out  16  response data; held stable from send_resp until the next send_resp
- send_resp  out  1  one-cycle strobe to start transmission
- tx_done  in  1  transmitter finished sending resp
- nv_addr  out  3  NV_MEM address
- nv_wdata  out  16  NV_MEM write data
- nv_we  out  1  one-cycle write strobe
- nv_rdy  in  1  NV_MEM write complete / idle
- nv_rdata  in  16  NV_MEM read data; valid one clock after nv_addr is presented
- chnl  out  3  A2D channel select
- strt_cnv  out  1  one-cycle conversion start
- cnv_cmplt  in  1  conversion complete
- a2d_res  in  16  signed conversion result; valid when cnv_cmplt

Behaviour:
- Reset values: every output is 0; the FSM is in IDLE. Asserting reset mid-operation aborts immediately and no response is sent.
- NV map: addr 5 = Tco, 6 = Offset, 7 = Gain. All coefficients are signed Q2.14 (16'h4000 = 1.0, 16'hC000 = -1.0, 16'hA000 = -1.5).
- IDLE:
  - On cmd_rdy, latch cmd and pulse clr_cmd_rdy in the same cycle.
  - cmd_rdy is ignored in every state other than IDLE.
- Opcode 8'h05/06/07 (write):
  - NV_WR: wait for nv_rdy, then pulse nv_we with nv_addr = opcode[2:0] and nv_wdata = data.
  - NV_WAIT: wait one cycle, then for nv_rdy high.
  - RESP with resp = ACK_VAL.
- Opcode 8'h00 (corrected read): RD_TCO -> RD_OFF -> RD_GAIN, one cycle each plus one latency cycle, registering each coefficient. Then:
  - CNV_P: pulse strt_cnv with chnl = P_CHNL.
  - WAIT_P: wait for cnv_cmplt; latch P.
  - CNV_T / WAIT_T: same sequence on T_CHNL; latch PTAT.
  - MUL1: prod = Tco*PTAT (32-bit signed); tc = prod >>> 14, saturated to 16-bit signed.
  - ADD: sum = P + Offset + tc, computed in 18 bits, saturated to [16'h8000, 16'h7FFF].
  - MUL2: out = (Gain*sum) >>> 14, saturated to 16 bits.
  - RESP with resp = out.
- Opcode 8'h04: raw pressure. CNV_P / WAIT_P only, then resp = P.
- Any other opcode: RESP with resp = ERR_VAL.
- RESP: drive resp and pulse send_resp for one cycle, then go to WAIT_TX. WAIT_TX waits for tx_done, then returns to IDLE.
- Latency: a corrected read reaches send_resp 3 cycles after the last cnv_cmplt.
- Arithmetic shift is toward -inf. Saturation is applied at each of the three stages independently.
- Simultaneous events:
  - cnv_cmplt arriving in the same cycle as strt_cnv is not counted; WAIT states sample from the following cycle.
  - tx_done and a new cmd_rdy in the same cycle: return to IDLE first; the command is accepted next cycle.

Optional Feature:
- Macro PSIC_CMD_TIMEOUT_EN.
- When defined: a counter clears on every state change and increments while in NV_WAIT, WAIT_P or WAIT_T. On reaching TIMEOUT, the FSM aborts to RESP with resp = 16'hDEAD.
- When undefined: no counter is instantiated and WAIT states wait indefinitely.

Test Plan:
1. cmd 24'h07_4000, nv_rdy high -> nv_we pulse with addr 7 / data 16'h4000, then send_resp with resp = 16'hA5A5.
2. Tco = 0, Offset = 0, Gain = 16'h4000; cmd 24'h00_0000 with P = 16'h3456, PTAT = 16'h1000 -> resp = 16'h3456; strt_cnv pulses exactly twice, chnl 0 then 1.
3. Gain = 16'h5000, P = 16'h3ABC -> resp = 16'h496B. Then Offset = 16'h0025, P = 16'h7000 -> resp = 16'h7FFF (positive saturation).
4. Tco = 16'hC000, Offset = 16'h6668, Gain = 16'hA000, P = 16'h4000, PTAT = 16'h0100 -> resp = 16'h8000 (negative saturation).
5. cmd 24'h03_1234 -> resp = 16'hEEEE with no nv_we or strt_cnv. A cmd_rdy raised during WAIT_TX must not be accepted until after tx_done.
6. rst_n dropped during WAIT_P -> all outputs 0 asynchronously, no send_resp. With PSIC_CMD_TIMEOUT_EN defined and cnv_cmplt held low -> resp = 16'hDEAD after 4096 cycles.

Source files
------------

// File: rtl/psic_cmd_proc.sv
// PSIC command processor: NV_MEM writes plus raw and Tco/Offset/Gain-corrected
// pressure reads. Define PSIC_CMD_TIMEOUT_EN to add a watchdog on the wait states.
module psic_cmd_proc #(
  parameter logic [2:0]  P_CHNL  = 3'd0,
  parameter logic [2:0]  T_CHNL  = 3'd1,
  parameter logic [15:0] ACK_VAL = 16'hA5A5,
  parameter logic [15:0] ERR_VAL = 16'hEEEE
`ifdef PSIC_CMD_TIMEOUT_EN
  ,
  parameter int          TIMEOUT = 4096
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_rdy,
  input  logic [23:0] cmd,
  output logic        clr_cmd_rdy,
  output logic [15:0] resp,
  output logic        send_resp,
  input  logic        tx_done,
  output logic [2:0]  nv_addr,
  output logic [15:0] nv_wdata,
  output logic        nv_we,
  input  logic        nv_rdy,
  input  logic [15:0] nv_rdata,
  output logic [2:0]  chnl,
  output logic        strt_cnv,
  input  logic        cnv_cmplt,
  input  logic [15:0] a2d_res
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,  NV_WR   = 4'd1,  NV_WAIT = 4'd2,  RD_TCO = 4'd3,
    RD_OFF  = 4'd4,  RD_GAIN = 4'd5,  RD_LAT  = 4'd6,  CNV_P  = 4'd7,
    WAIT_P  = 4'd8,  CNV_T   = 4'd9,  WAIT_T  = 4'd10, MUL1   = 4'd11,
    ADD     = 4'd12, MUL2    = 4'd13, RESP    = 4'd14, WAIT_TX = 4'd15
  } state_t;

  state_t             state_r;
  logic [7:0]         op_r;
  logic [15:0]        data_r;
  logic signed [15:0] tco_r, off_r, gain_r, p_r, t_r, tc_r, sum_r;
  logic               clr_cmd_rdy_r, send_resp_r, nv_we_r, strt_cnv_r;
  logic [15:0]        resp_r, nv_wdata_r;
  logic [2:0]         nv_addr_r, chnl_r;

  logic signed [15:0] mul_a_s, mul_b_s;
  logic signed [31:0] prod_s, prod_sh_s;
  logic signed [17:0] add_s;
  logic               timeout_s;

  function automatic logic [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)
      return 16'h7FFF;
    else if (v < -32'sd32768)
      return 16'h8000;
    else
      return v[15:0];
  endfunction

`ifdef PSIC_CMD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] to_cnt_r;

  // Watchdog: counts cycles spent in a wait state; wait states are never adjacent, so leaving one clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      to_cnt_r <= {CW{1'b0}};
    else if (state_r == NV_WAIT || state_r == WAIT_P || state_r == WAIT_T)
      to_cnt_r <= to_cnt_r + CW'(1);
    else
      to_cnt_r <= {CW{1'b0}};
  end

  assign timeout_s = (to_cnt_r == CW'(TIMEOUT));
`else
  assign timeout_s = 1'b0;
`endif

  // Shared multiplier operand select: Tco*PTAT in MUL1, Gain*sum otherwise
  always_comb begin
    mul_a_s = gain_r;
    mul_b_s = sum_r;
    if (state_r == MUL1) begin
      mul_a_s = tco_r;
      mul_b_s = t_r;
    end else begin
      mul_a_s = gain_r;
      mul_b_s = sum_r;
    end
  end

  assign prod_s    = 32'(mul_a_s) * 32'(mul_b_s);
  assign prod_sh_s = prod_s >>> 5'd14;
  assign add_s     = {{2{p_r[15]}}, p_r} + {{2{off_r[15]}}, off_r} + {{2{tc_r[15]}}, tc_r};

  // Command FSM with registered outputs; entering RESP loads resp and raises send_resp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      op_r          <= 8'h00;
      data_r        <= 16'h0000;
      tco_r         <= 16'sh0000;
      off_r         <= 16'sh0000;
      gain_r        <= 16'sh0000;
      p_r           <= 16'sh0000;
      t_r           <= 16'sh0000;
      tc_r          <= 16'sh0000;
      sum_r         <= 16'sh0000;
      clr_cmd_rdy_r <= 1'b0;
      send_resp_r   <= 1'b0;
      nv_we_r       <= 1'b0;
      strt_cnv_r    <= 1'b0;
      resp_r        <= 16'h0000;
      nv_wdata_r    <= 16'h0000;
      nv_addr_r     <= 3'd0;
      chnl_r        <= 3'd0;
    end else begin
      clr_cmd_rdy_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cmd_rdy) begin
            op_r          <= cmd[23:16];
            data_r        <= cmd[15:0];
            clr_cmd_rdy_r <= 1'b1;
            case (cmd[23:16])
              8'h05, 8'h06, 8'h07: state_r <= NV_WR;
              8'h00: begin
                nv_addr_r <= 3'd5;
                state_r   <= RD_TCO;
              end
              8'h04: state_r <= CNV_P;
              default: begin
                resp_r      <= ERR_VAL;
                send_resp_r <= 1'b1;
                state_r     <= RESP;
              end
            endcase
          end
        end
        NV_WR: begin
          if (nv_rdy) begin
            nv_we_r    <= 1'b1;
            nv_addr_r  <= op_r[2:0];
            nv_wdata_r <= data_r;
            state_r    <= NV_WAIT;
          end
        end
        NV_WAIT: begin
          // nv_we_r still high marks the first cycle, where nv_rdy is not yet meaningful
          nv_we_r <= 1'b0;
          if (timeout_s) begin
            resp_r      <= 16'hDEAD;
            send_resp_r <= 1'b1;
            state_r     <= RESP;
          end else if (!nv_we_r && nv_rdy) begin
            resp_r      <= ACK_VAL;
            send_resp_r <= 1'b1;
            state_r     <= RESP;
          end
        end
        RD_TCO: begin
          nv_addr_r <= 3'd6;
          state_r   <= RD_OFF;
        end
        RD_OFF: begin
          tco_r     <= nv_rdata;
          nv_addr_r <= 3'd7;
          state_r   <= RD_GAIN;
        end
        RD_GAIN: begin
          off_r   <= nv_rdata;
          state_r <= RD_LAT;
        end
        RD_LAT: begin
          gain_r  <= nv_rdata;
          state_r <= CNV_P;
        end
        CNV_P: begin
          strt_cnv_r <= 1'b1;
          chnl_r     <= P_CHNL;
          state_r    <= WAIT_P;
        end
        WAIT_P: begin
          // a completion coinciding with the start pulse belongs to no conversion of ours
          strt_cnv_r <= 1'b0;
          if (timeout_s) begin
            resp_r      <= 16'hDEAD;
            send_resp_r <= 1'b1;
            state_r     <= RESP;
          end else if (!strt_cnv_r && cnv_cmplt) begin
            p_r <= a2d_res;
            if (op_r == 8'h04) begin
              resp_r      <= a2d_res;
              send_resp_r <= 1'b1;
              state_r     <= RESP;
            end else begin
              state_r <= CNV_T;
            end
          end
        end
        CNV_T: begin
          strt_cnv_r <= 1'b1;
          chnl_r     <= T_CHNL;
          state_r    <= WAIT_T;
        end
        WAIT_T: begin
          strt_cnv_r <= 1'b0;
          if (timeout_s) begin
            resp_r      <= 16'hDEAD;
            send_resp_r <= 1'b1;
            state_r     <= RESP;
          end else if (!strt_cnv_r && cnv_cmplt) begin
            t_r     <= a2d_res;
            state_r <= MUL1;
          end
        end
        MUL1: begin
          tc_r    <= sat16(prod_sh_s);
          state_r <= ADD;
        end
        ADD: begin
          sum_r   <= sat16({{14{add_s[17]}}, add_s});
          state_r <= MUL2;
        end
        MUL2: begin
          resp_r      <= sat16(prod_sh_s);
          send_resp_r <= 1'b1;
          state_r     <= RESP;
        end
        RESP: begin
          send_resp_r <= 1'b0;
          state_r     <= WAIT_TX;
        end
        WAIT_TX: begin
          if (tx_done)
            state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign clr_cmd_rdy = clr_cmd_rdy_r;
  assign resp        = resp_r;
  assign send_resp   = send_resp_r;
  assign nv_addr     = nv_addr_r;
  assign nv_wdata    = nv_wdata_r;
  assign nv_we       = nv_we_r;
  assign chnl        = chnl_r;
  assign strt_cnv    = strt_cnv_r;

endmodule

// File: tb/tb_psic_cmd_proc.sv
// Directed self-checking bench for psic_cmd_proc with small NV_MEM and A2D models.
`timescale 1ns/1ps
module tb_psic_cmd_proc;
  logic        clk = 1'b0;
  logic        rst_n, cmd_rdy, tx_done, nv_rdy;
  logic [23:0] cmd;
  logic        clr_cmd_rdy, send_resp, nv_we, strt_cnv;
  logic [15:0] resp, nv_wdata, nv_rdata;
  logic [2:0]  nv_addr, chnl;
  logic        cnv_cmplt;
  logic [15:0] a2d_res;

  logic        model_cmplt, force_cmplt;
  logic [15:0] model_res, p_val, t_val;
  bit          a2d_en;
  logic [15:0] mem [0:7];
  logic [2:0]  chnl_log [0:63];
  logic [2:0]  we_addr;
  logic [15:0] we_data;
  int total = 0, bad = 0, cyc = 0;
  int strt_cnt = 0, we_cnt = 0, resp_cnt = 0, cmplt_cyc = 0, resp_seen_cyc = 0;

  assign cnv_cmplt = model_cmplt | force_cmplt;
  assign a2d_res   = model_cmplt ? model_res : 16'h7777;

  psic_cmd_proc dut (
    .clk(clk), .rst_n(rst_n), .cmd_rdy(cmd_rdy), .cmd(cmd), .clr_cmd_rdy(clr_cmd_rdy),
    .resp(resp), .send_resp(send_resp), .tx_done(tx_done), .nv_addr(nv_addr),
    .nv_wdata(nv_wdata), .nv_we(nv_we), .nv_rdy(nv_rdy), .nv_rdata(nv_rdata),
    .chnl(chnl), .strt_cnv(strt_cnv), .cnv_cmplt(cnv_cmplt), .a2d_res(a2d_res)
  );

  always #5 clk = ~clk;

  // NV_MEM model: read data one clock after the address, plus a cycle counter
  always @(posedge clk) begin
    if (nv_we) mem[nv_addr] <= nv_wdata;
    nv_rdata <= mem[nv_addr];
    cyc <= cyc + 1;
  end

  // Pulse monitor
  initial begin
    forever begin
      @(posedge clk); #1;
      if (strt_cnv) begin
        chnl_log[strt_cnt[5:0]] = chnl;
        strt_cnt = strt_cnt + 1;
      end
      if (nv_we) begin
        we_cnt  = we_cnt + 1;
        we_addr = nv_addr;
        we_data = nv_wdata;
      end
      if (send_resp) resp_cnt = resp_cnt + 1;
    end
  end

  // A2D model: completes three cycles after seeing strt_cnv
  initial begin
    model_cmplt = 1'b0;
    model_res   = 16'h0000;
    forever begin
      @(posedge clk); #1;
      if (strt_cnv && a2d_en) begin
        model_res = (chnl == 3'd1) ? t_val : p_val;
        repeat (3) @(posedge clk);
        #1 model_cmplt = 1'b1;
        cmplt_cyc = cyc;
        @(posedge clk);
        #1 model_cmplt = 1'b0;
      end
    end
  end

  task automatic tick;
    @(posedge clk); #2;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [23:0] c);
    int n = 0;
    cmd = c;
    cmd_rdy = 1'b1;
    while (n < 50 && !clr_cmd_rdy) begin tick(); n++; end
    chk("cmd_accept", {47'd0, clr_cmd_rdy}, 48'd1);
    cmd_rdy = 1'b0;
  endtask

  task automatic wait_resp(input logic [15:0] exp, input string tag, input int limit);
    int n = 0;
    while (n < limit && !send_resp) begin tick(); n++; end
    resp_seen_cyc = cyc;
    chk({tag, "_strobe"}, {47'd0, send_resp}, 48'd1);
    chk(tag, {32'd0, resp}, {32'd0, exp});
    tick();
    chk({tag, "_pulse"}, {47'd0, send_resp}, 48'd0);
  endtask

  task automatic finish_tx(input logic [15:0] exp);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("resp_hold", {32'd0, resp}, {32'd0, exp});
  endtask

  task automatic nv_write(input logic [2:0] a, input logic [15:0] d);
    send_cmd({5'd0, a, d});
    wait_resp(16'hA5A5, "nv_ack", 100);
    finish_tx(16'hA5A5);
  endtask

  task automatic wait_strt;
    int n = 0;
    while (n < 50 && !strt_cnv) begin tick(); n++; end
    chk("strt_seen", {47'd0, strt_cnv}, 48'd1);
  endtask

  function automatic logic [47:0] outs();
    return {6'd0, clr_cmd_rdy, resp, send_resp, nv_addr, nv_wdata, nv_we, chnl, strt_cnv};
  endfunction

  initial begin
    int base, base_we, base_resp, b1;
    rst_n = 1'b0; cmd_rdy = 1'b0; cmd = 24'h0; tx_done = 1'b0; nv_rdy = 1'b1;
    force_cmplt = 1'b0; a2d_en = 1'b1; p_val = 16'h0; t_val = 16'h0;
    tick(); tick();
    chk("reset_outputs", outs(), 48'd0);
    rst_n = 1'b1;
    tick();

    // 1: gain write
    base_we = we_cnt;
    send_cmd(24'h07_4000);
    wait_resp(16'hA5A5, "wr_ack", 100);
    chk("wr_we_count", we_cnt - base_we, 48'd1);
    chk("wr_addr", {45'd0, we_addr}, 48'd7);
    chk("wr_data", {32'd0, we_data}, 48'h4000);
    finish_tx(16'hA5A5);
    nv_write(3'd5, 16'h0000);
    nv_write(3'd6, 16'h0000);

    // 2: unity gain; a stray completion alongside the start pulse must be ignored
    p_val = 16'h3456; t_val = 16'h1000;
    base = strt_cnt;
    send_cmd(24'h00_0000);
    wait_strt();
    force_cmplt = 1'b1;
    tick();
    force_cmplt = 1'b0;
    wait_resp(16'h3456, "rd_unity", 200);
    // cnv_cmplt is sampled one edge after cmplt_cyc; send_resp rises three edges after that
    chk("latency", resp_seen_cyc - cmplt_cyc, 48'd4);
    chk("strt_count", strt_cnt - base, 48'd2);
    b1 = base + 1;
    chk("chnl_first", {45'd0, chnl_log[base[5:0]]}, 48'd0);
    chk("chnl_second", {45'd0, chnl_log[b1[5:0]]}, 48'd1);
    finish_tx(16'h3456);

    // 3: gain 1.25, then positive saturation
    nv_write(3'd7, 16'h5000);
    p_val = 16'h3ABC;
    send_cmd(24'h00_0000);
    wait_resp(16'h496B, "rd_gain125", 200);
    finish_tx(16'h496B);
    nv_write(3'd6, 16'h0025);
    p_val = 16'h7000;
    send_cmd(24'h00_0000);
    wait_resp(16'h7FFF, "rd_pos_sat", 200);
    finish_tx(16'h7FFF);

    // 4: negative saturation
    nv_write(3'd5, 16'hC000);
    nv_write(3'd6, 16'h6668);
    nv_write(3'd7, 16'hA000);
    p_val = 16'h4000; t_val = 16'h0100;
    send_cmd(24'h00_0000);
    wait_resp(16'h8000, "rd_neg_sat", 200);
    finish_tx(16'h8000);

    // raw read: one conversion on the pressure channel
    p_val = 16'h1234;
    base = strt_cnt;
    send_cmd(24'h04_0000);
    wait_resp(16'h1234, "rd_raw", 200);
    chk("raw_strt_count", strt_cnt - base, 48'd1);
    chk("raw_chnl", {45'd0, chnl_log[base[5:0]]}, 48'd0);
    finish_tx(16'h1234);

    // write stalls while NV_MEM is busy
    nv_rdy = 1'b0;
    base_we = we_cnt;
    send_cmd(24'h05_0000);
    repeat (4) tick();
    chk("nv_busy_no_we", we_cnt - base_we, 48'd0);
    nv_rdy = 1'b1;
    wait_resp(16'hA5A5, "nv_busy_ack", 100);
    chk("nv_busy_we", we_cnt - base_we, 48'd1);
    finish_tx(16'hA5A5);

    // 5: unknown opcode, and a command arriving during WAIT_TX
    base = strt_cnt; base_we = we_cnt;
    send_cmd(24'h03_1234);
    wait_resp(16'hEEEE, "err_resp", 100);
    chk("err_no_we", we_cnt - base_we, 48'd0);
    chk("err_no_strt", strt_cnt - base, 48'd0);
    cmd = 24'h06_0000;
    cmd_rdy = 1'b1;
    base = 0;
    repeat (3) begin tick(); if (clr_cmd_rdy) base++; end
    chk("wait_tx_ignore", base, 48'd0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("tx_done_no_accept", {47'd0, clr_cmd_rdy}, 48'd0);
    tick();
    chk("accept_after_tx", {47'd0, clr_cmd_rdy}, 48'd1);
    cmd_rdy = 1'b0;
    wait_resp(16'hA5A5, "late_cmd_ack", 100);
    finish_tx(16'hA5A5);

    // 6: reset during WAIT_P
    a2d_en = 1'b0;
    send_cmd(24'h04_0000);
    wait_strt();
    repeat (3) tick();
    base_resp = resp_cnt;
    #1 rst_n = 1'b0;
    #1 chk("async_reset", outs(), 48'd0);
    tick(); tick();
    rst_n = 1'b1;
    a2d_en = 1'b1;
    repeat (10) tick();
    chk("reset_no_resp", resp_cnt - base_resp, 48'd0);
    chk("reset_idle_outputs", outs(), 48'd0);
    p_val = 16'h0BEE;
    send_cmd(24'h04_0000);
    wait_resp(16'h0BEE, "post_reset_raw", 200);
    finish_tx(16'h0BEE);

`ifdef PSIC_CMD_TIMEOUT_EN
    a2d_en = 1'b0;
    send_cmd(24'h04_0000);
    wait_resp(16'hDEAD, "timeout", 6000);
    finish_tx(16'hDEAD);
    a2d_en = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
